// File: rtl/dff_share_arbiter_if.sv
// rtl/dff_share_arbiter_if.sv - requester/arbiter bundle for the shared register
interface dff_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [OW-1:0]         owner;
  logic [WIDTH-1:0]      q;
  logic                  q_load;
  logic                  q_valid;

  modport master (
    output req, wdata,
    input  gnt, owner, q, q_load, q_valid
  );

  modport slave (
    input  req, wdata,
    output gnt, owner, q, q_load, q_valid
  );
endinterface

// File: rtl/dff_share_arbiter.sv
// rtl/dff_share_arbiter.sv - round-robin arbiter sharing one register among requesters
module dff_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  dff_share_arbiter_if.slave bus
);
  localparam int OW = $clog2(NREQ);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]    state;
  logic [OW-1:0] ptr;
  logic [OW-1:0] winner;
  logic          found;
  int            idx;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      bus.gnt     <= '0;
      bus.owner   <= '0;
      bus.q       <= '0;
      bus.q_load  <= 1'b0;
      bus.q_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.q_load <= 1'b0;
          if (found) begin
            bus.owner <= winner;
            bus.gnt   <= NREQ'(1) << winner;
            state     <= GRANT;
          end else begin
            bus.gnt <= '0;
          end
        end
        GRANT: begin
          // Data is taken now, so a requester may update wdata after seeing gnt.
          bus.q       <= bus.wdata[bus.owner*WIDTH +: WIDTH];
          bus.q_valid <= 1'b1;
          bus.q_load  <= 1'b1;
          bus.gnt     <= '0;
          ptr         <= (bus.owner == OW'(NREQ - 1)) ? '0 : bus.owner + 1'b1;
          state       <= RELEASE;
        end
        RELEASE: begin
          bus.q_load <= 1'b0;
          bus.gnt    <= '0;
          state      <= IDLE;
        end
        default: begin
          bus.gnt    <= '0;
          bus.q_load <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dff_share_arbiter.sv
// tb/tb_dff_share_arbiter.sv - scoreboard bench for dff_share_arbiter
module tb_dff_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  typedef struct {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbq[$];

  dff_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  dff_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.q_load === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.req   = 4'hF;
    bus.wdata = 32'h44332211;
    repeat (3) @(negedge clk);
    total++;
    if (bus.gnt !== 4'h0 || bus.q !== 8'h00 || bus.q_valid !== 1'b0 ||
        bus.q_load !== 1'b0 || bus.owner !== 2'd0) begin
      bad++;
      $display("FAIL reset_state gnt=%h q=%h q_valid=%b q_load=%b owner=%0d want all zero",
               bus.gnt, bus.q, bus.q_valid, bus.q_load, bus.owner);
    end
    reset   = 1'b1;
    bus.req = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'h0 || bus.q_load !== 1'b0) begin
        bad++;
        $display("FAIL idle_no_req cycle %0d gnt=%h q_load=%b want 0/0", i, bus.gnt, bus.q_load);
      end
    end
  endtask

  task automatic test_single();
    bit   ok;
    exp_t e;
    @(negedge clk);
    bus.req = 4'b0100;
    bus.wdata[2*WIDTH +: WIDTH] = 8'hA5;
    sbq.push_back('{owner: 2'd2, data: 8'hA5});
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b0100) begin
      bad++;
      $display("FAIL single_gnt gnt=%b want 0100", bus.gnt);
    end
    bus.req = 4'h0;
    wait_load(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_load no q_load seen, want q_load pulse");
    end else begin
      e = sbq.pop_front();
      if (bus.q !== e.data || bus.owner !== e.owner || bus.q_valid !== 1'b1 || bus.gnt !== 4'h0) begin
        bad++;
        $display("FAIL single_load q=%h owner=%0d q_valid=%b gnt=%b want q=%h owner=%0d q_valid=1 gnt=0",
                 bus.q, bus.owner, bus.q_valid, bus.gnt, e.data, e.owner);
      end
    end
    @(negedge clk);
    total++;
    if (bus.q_load !== 1'b0 || bus.q !== 8'hA5 || bus.gnt !== 4'h0) begin
      bad++;
      $display("FAIL single_after q_load=%b q=%h gnt=%b want 0/a5/0", bus.q_load, bus.q, bus.gnt);
    end
  endtask

  task automatic test_round_robin();
    bit   ok;
    exp_t e;
    int   last;
    logic [7:0] vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    last = 0;
    do_reset();
    bus.wdata = 32'h44332211;
    bus.req   = 4'hF;
    for (int k = 0; k < 5; k++)
      sbq.push_back('{owner: 2'(k % 4), data: vals[k % 4]});
    for (int k = 0; k < 5; k++) begin
      wait_load(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rr_load %0d no q_load seen", k);
      end else begin
        e = sbq.pop_front();
        if (bus.q !== e.data || bus.owner !== e.owner) begin
          bad++;
          $display("FAIL rr_load %0d q=%h owner=%0d want q=%h owner=%0d",
                   k, bus.q, bus.owner, e.data, e.owner);
        end
        if (k > 0) begin
          total++;
          if (cyc - last !== 3) begin
            bad++;
            $display("FAIL rr_spacing %0d got=%0d want=3", k, cyc - last);
          end
        end
        last = cyc;
      end
      if (k == 4) bus.req = 4'h0;
    end
  endtask

  task automatic test_wrap();
    bit   ok;
    exp_t e;
    do_reset();
    bus.wdata = 32'h44332211;
    bus.req   = 4'b1000;
    sbq.push_back('{owner: 2'd3, data: 8'h44});
    sbq.push_back('{owner: 2'd0, data: 8'h11});
    sbq.push_back('{owner: 2'd1, data: 8'h22});
    for (int j = 0; j < 3; j++) begin
      wait_load(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL wrap_load %0d no q_load seen", j);
      end else begin
        e = sbq.pop_front();
        if (bus.q !== e.data || bus.owner !== e.owner) begin
          bad++;
          $display("FAIL wrap_load %0d q=%h owner=%0d want q=%h owner=%0d",
                   j, bus.q, bus.owner, e.data, e.owner);
        end
      end
      bus.req = (j == 0) ? 4'b0011 : ((j == 2) ? 4'h0 : bus.req);
    end
  endtask

  task automatic test_data_timing();
    bit   ok;
    exp_t e;
    @(negedge clk);
    bus.wdata[1*WIDTH +: WIDTH] = 8'h10;
    bus.req = 4'b0010;
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b0010) begin
      bad++;
      $display("FAIL timing_gnt gnt=%b want 0010", bus.gnt);
    end
    bus.wdata[1*WIDTH +: WIDTH] = 8'h20;
    bus.req = 4'h0;
    sbq.push_back('{owner: 2'd1, data: 8'h20});
    wait_load(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL timing_load no q_load seen after req dropped in grant");
    end else begin
      e = sbq.pop_front();
      if (bus.q !== e.data || bus.owner !== e.owner) begin
        bad++;
        $display("FAIL timing_load q=%h owner=%0d want q=%h owner=%0d", bus.q, bus.owner, e.data, e.owner);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    exp_t e;
    @(negedge clk);
    bus.wdata[0 +: WIDTH] = 8'h5A;
    bus.req = 4'b0010;
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b0010) begin
      bad++;
      $display("FAIL mid_gnt gnt=%b want 0010", bus.gnt);
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.gnt !== 4'h0 || bus.q !== 8'h00 || bus.q_valid !== 1'b0 || bus.q_load !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset gnt=%b q=%h q_valid=%b q_load=%b want all zero",
               bus.gnt, bus.q, bus.q_valid, bus.q_load);
    end
    bus.req = 4'b0011;
    @(negedge clk);
    reset = 1'b1;
    sbq.push_back('{owner: 2'd0, data: 8'h5A});
    wait_load(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL mid_restart no q_load seen");
    end else begin
      e = sbq.pop_front();
      if (bus.q !== e.data || bus.owner !== e.owner) begin
        bad++;
        $display("FAIL mid_restart q=%h owner=%0d want q=%h owner=%0d", bus.q, bus.owner, e.data, e.owner);
      end
    end
    bus.req = 4'h0;
  endtask

  initial begin
    bus.req   = '0;
    bus.wdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_data_timing();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
